// File: rtl/fdc_pkg.sv
// Shared floppy-controller constants and the byte-wise CRC-16-CCITT helper
// used by both the read and write paths.
package fdc_pkg;

    localparam logic [15:0] MFM_MARK_A1 = 16'h4489;
    localparam logic [15:0] MFM_MARK_C2 = 16'h5224;
    localparam logic [7:0]  DATA_A1     = 8'hA1;

    localparam logic [15:0] CRC16_POLY  = 16'h1021;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC16_A1X3  = 16'hCDB4;

    typedef enum logic {
        DEC_HUNT,
        DEC_ALIGNED
    } dec_state_t;

    // MSB-first, unreflected, no final XOR; one full byte per call.
    function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc,
                                                     input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_ccitt_byte_update.sv
// Combinational one-byte CRC-16-CCITT step; shared with the write path.
module crc16_ccitt_byte_update
    import fdc_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    assign crc_out = crc16_ccitt_byte(crc_in, data_in);

endmodule

// File: rtl/mfm_byte_decoder.sv
// Aligns the MFM cell stream to A1 marks, strips clock cells into bytes,
// flags clock-rule violations and tracks the per-field CRC.
module mfm_byte_decoder
    import fdc_pkg::*;
#(
    parameter int MAX_BAD_BYTES = 4,
    parameter bit CHECK_CLOCKS  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        mark_in,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        byte_is_mark,
    output logic        clk_err,
    output logic [15:0] crc,
    output logic        crc_ok,
    output logic        aligned,
    output logic        sync_lost
);

    dec_state_t  state, state_nxt;
    logic [3:0]  cell_cnt, cell_cnt_nxt;
    logic [7:0]  data_sr, data_sr_nxt;
    logic        clk_cell, clk_cell_nxt;
    logic        prev_data, prev_data_nxt;
    logic        err_acc, err_acc_nxt;
    logic        byte_pend, byte_pend_nxt;
    logic [3:0]  bad_cnt, bad_cnt_nxt;
    logic        last_was_mark, last_was_mark_nxt;

    logic [7:0]  byte_out_nxt;
    logic        byte_valid_nxt, byte_is_mark_nxt, clk_err_nxt;
    logic [15:0] crc_nxt;
    logic        crc_ok_nxt, sync_lost_nxt;

    logic [15:0] crc_base, crc_upd;
    logic [7:0]  crc_data;
    logic [4:0]  bad_inc;

    // A fresh mark sequence restarts the CRC; consecutive marks accumulate.
    assign crc_base = (mark_in && !last_was_mark) ? CRC16_INIT : crc;
    assign crc_data = mark_in ? DATA_A1 : data_sr;
    assign bad_inc  = {1'b0, bad_cnt} + 5'd1;

    crc16_ccitt_byte_update u_crc (
        .crc_in  (crc_base),
        .data_in (crc_data),
        .crc_out (crc_upd)
    );

    assign aligned = (state == DEC_ALIGNED);

    always_comb begin
        state_nxt         = state;
        cell_cnt_nxt      = cell_cnt;
        data_sr_nxt       = data_sr;
        clk_cell_nxt      = clk_cell;
        prev_data_nxt     = prev_data;
        err_acc_nxt       = err_acc;
        byte_pend_nxt     = byte_pend;
        bad_cnt_nxt       = bad_cnt;
        last_was_mark_nxt = last_was_mark;
        byte_out_nxt      = byte_out;
        byte_valid_nxt    = 1'b0;
        byte_is_mark_nxt  = 1'b0;
        clk_err_nxt       = 1'b0;
        crc_nxt           = crc;
        crc_ok_nxt        = 1'b0;
        sync_lost_nxt     = 1'b0;

        if (!enable) begin
            state_nxt         = DEC_HUNT;
            cell_cnt_nxt      = 4'd0;
            data_sr_nxt       = 8'h00;
            clk_cell_nxt      = 1'b0;
            prev_data_nxt     = 1'b0;
            err_acc_nxt       = 1'b0;
            byte_pend_nxt     = 1'b0;
            bad_cnt_nxt       = 4'd0;
            last_was_mark_nxt = 1'b0;
            byte_out_nxt      = 8'h00;
            crc_nxt           = CRC16_INIT;
        end else if (mark_in) begin
            // The mark replaces whatever partial or pending byte was in flight.
            state_nxt         = DEC_ALIGNED;
            cell_cnt_nxt      = 4'd0;
            data_sr_nxt       = 8'h00;
            err_acc_nxt       = 1'b0;
            byte_pend_nxt     = 1'b0;
            prev_data_nxt     = 1'b1;
            bad_cnt_nxt       = 4'd0;
            last_was_mark_nxt = 1'b1;
            byte_out_nxt      = DATA_A1;
            byte_valid_nxt    = 1'b1;
            byte_is_mark_nxt  = 1'b1;
            crc_nxt           = crc_upd;
            crc_ok_nxt        = (crc_upd == 16'h0000);
        end else if (state == DEC_ALIGNED) begin
            if (byte_pend) begin
                byte_pend_nxt     = 1'b0;
                err_acc_nxt       = 1'b0;
                last_was_mark_nxt = 1'b0;
                byte_out_nxt      = data_sr;
                byte_valid_nxt    = 1'b1;
                clk_err_nxt       = err_acc;
                bad_cnt_nxt       = err_acc ? bad_inc[3:0] : 4'd0;
                if (err_acc && (bad_inc >= 5'(MAX_BAD_BYTES))) begin
                    state_nxt     = DEC_HUNT;
                    sync_lost_nxt = 1'b1;
                    crc_ok_nxt    = (crc == 16'h0000);
                end else begin
                    crc_nxt       = crc_upd;
                    crc_ok_nxt    = (crc_upd == 16'h0000);
                end
            end else if (bit_valid) begin
                cell_cnt_nxt = cell_cnt + 4'd1;
                if (cell_cnt[0]) begin
                    data_sr_nxt   = {data_sr[6:0], bit_in};
                    prev_data_nxt = bit_in;
                    if (CHECK_CLOCKS && (clk_cell != ~(prev_data | bit_in)))
                        err_acc_nxt = 1'b1;
                    if (cell_cnt == 4'd15)
                        byte_pend_nxt = 1'b1;
                end else begin
                    clk_cell_nxt = bit_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= DEC_HUNT;
            cell_cnt      <= 4'd0;
            data_sr       <= 8'h00;
            clk_cell      <= 1'b0;
            prev_data     <= 1'b0;
            err_acc       <= 1'b0;
            byte_pend     <= 1'b0;
            bad_cnt       <= 4'd0;
            last_was_mark <= 1'b0;
            byte_out      <= 8'h00;
            byte_valid    <= 1'b0;
            byte_is_mark  <= 1'b0;
            clk_err       <= 1'b0;
            crc           <= CRC16_INIT;
            crc_ok        <= 1'b0;
            sync_lost     <= 1'b0;
        end else begin
            state         <= state_nxt;
            cell_cnt      <= cell_cnt_nxt;
            data_sr       <= data_sr_nxt;
            clk_cell      <= clk_cell_nxt;
            prev_data     <= prev_data_nxt;
            err_acc       <= err_acc_nxt;
            byte_pend     <= byte_pend_nxt;
            bad_cnt       <= bad_cnt_nxt;
            last_was_mark <= last_was_mark_nxt;
            byte_out      <= byte_out_nxt;
            byte_valid    <= byte_valid_nxt;
            byte_is_mark  <= byte_is_mark_nxt;
            clk_err       <= clk_err_nxt;
            crc           <= crc_nxt;
            crc_ok        <= crc_ok_nxt;
            sync_lost     <= sync_lost_nxt;
        end
    end

endmodule

// File: tb/tb_mfm_byte_decoder.sv
// Directed bench for mfm_byte_decoder: MFM-encodes bytes and A1 marks cell by
// cell and checks every strobe against hand-computed values.
module tb_mfm_byte_decoder;

    logic        clk = 1'b0;
    logic        reset, enable, bit_in, bit_valid, mark_in;
    logic [7:0]  byte_out;
    logic        byte_valid, byte_is_mark, clk_err, crc_ok, aligned, sync_lost;
    logic [15:0] crc;

    int   n_asserts = 0;
    int   n_fail    = 0;
    int   strobe_cnt = 0;
    int   s;
    logic prev_d;

    mfm_byte_decoder #(.MAX_BAD_BYTES(4), .CHECK_CLOCKS(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .mark_in      (mark_in),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .byte_is_mark (byte_is_mark),
        .clk_err      (clk_err),
        .crc          (crc),
        .crc_ok       (crc_ok),
        .aligned      (aligned),
        .sync_lost    (sync_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (byte_valid === 1'b1) strobe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cell(input logic b);
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    // MFM-encode one byte; bad_pos selects a data bit whose clock cell is forced to 0.
    task automatic send_data_cells(input logic [7:0] d, input int bad_pos);
        for (int i = 7; i >= 0; i--) begin
            logic c;
            c = ~(prev_d | d[i]);
            if (i == bad_pos) c = 1'b0;
            send_cell(c);
            send_cell(d[i]);
            prev_d = d[i];
        end
    endtask

    task automatic pulse_mark();
        mark_in = 1'b1;
        @(negedge clk);
        mark_in = 1'b0;
        prev_d  = 1'b1;
    endtask

    task automatic send_mark();
        logic [15:0] m;
        m = 16'h4489;
        for (int i = 15; i >= 0; i--) send_cell(m[i]);
        pulse_mark();
    endtask

    task automatic check_mark_strobe(input string tag);
        check({tag, "_valid"}, byte_valid, 1'b1);
        check({tag, "_byte"}, byte_out, 8'hA1);
        check({tag, "_is_mark"}, byte_is_mark, 1'b1);
        check({tag, "_clk_err"}, clk_err, 1'b0);
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] d, input int bad_pos,
                             input logic exp_err);
        send_data_cells(d, bad_pos);
        check({tag, "_early"}, byte_valid, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, byte_valid, 1'b1);
        check({tag, "_byte"}, byte_out, d);
        check({tag, "_is_mark"}, byte_is_mark, 1'b0);
        check({tag, "_clk_err"}, clk_err, exp_err);
    endtask

    initial begin
        logic [7:0] id_field [7];
        id_field = '{8'hFE, 8'h00, 8'h00, 8'h01, 8'h02, 8'hCA, 8'h6F};

        reset = 1'b1; enable = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; mark_in = 1'b0;
        prev_d = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", byte_valid, 1'b0);
        check("rst_aligned", aligned, 1'b0);
        check("rst_crc", crc, 16'hFFFF);
        check("rst_crc_ok", crc_ok, 1'b0);
        check("rst_sync_lost", sync_lost, 1'b0);
        check("rst_byte", byte_out, 8'h00);
        check("rst_clk_err", clk_err, 1'b0);
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // Cells without a mark are ignored.
        s = strobe_cnt;
        repeat (48) send_cell(1'($urandom_range(0, 1)));
        repeat (2) @(negedge clk);
        check("hunt_strobes", strobe_cnt, s);
        check("hunt_aligned", aligned, 1'b0);

        // Three marks 16 cells apart.
        s = strobe_cnt;
        send_mark();
        check_mark_strobe("mark1");
        check("mark1_aligned", aligned, 1'b1);
        send_mark();
        check_mark_strobe("mark2");
        send_mark();
        check_mark_strobe("mark3");
        check("a1x3_crc", crc, 16'hCDB4);
        check("a1x3_strobes", strobe_cnt, s + 3);

        // ID field with its own CRC closes to zero.
        for (int k = 0; k < 7; k++) begin
            recv_byte($sformatf("id%0d", k), id_field[k], -1, 1'b0);
            check($sformatf("id%0d_crc_ok", k), crc_ok, (k == 6));
        end
        check("id_crc", crc, 16'h0000);

        // Clock violations and loss of sync.
        recv_byte("bad0", 8'h00, 3, 1'b1);
        check("bad0_sync_lost", sync_lost, 1'b0);
        recv_byte("good0", 8'h00, -1, 1'b0);
        for (int j = 1; j <= 3; j++) begin
            recv_byte($sformatf("bad%0d", j), 8'h00, 3, 1'b1);
            check($sformatf("bad%0d_aligned", j), aligned, 1'b1);
            check($sformatf("bad%0d_sync_lost", j), sync_lost, 1'b0);
        end
        recv_byte("bad4", 8'h00, 3, 1'b1);
        check("bad4_sync_lost", sync_lost, 1'b1);
        check("bad4_aligned", aligned, 1'b0);
        @(negedge clk);
        check("sync_lost_pulse", sync_lost, 1'b0);
        s = strobe_cnt;
        send_data_cells(8'h00, 3);
        repeat (3) @(negedge clk);
        check("bad5_no_strobe", strobe_cnt, s);

        // Mark re-acquires; a mark on a pending byte wins.
        send_mark();
        check_mark_strobe("reacq");
        check("reacq_aligned", aligned, 1'b1);
        send_data_cells(8'h12, -1);
        s = strobe_cnt;
        pulse_mark();
        check_mark_strobe("pend_mark");
        @(negedge clk);
        check("pend_mark_strobes", strobe_cnt, s + 1);
        recv_byte("after_pend", 8'h4E, -1, 1'b0);

        // Mid-byte mark discards the partial byte.
        send_cell(1'b0); send_cell(1'b1); send_cell(1'b0);
        send_cell(1'b1); send_cell(1'b1); send_cell(1'b0);
        s = strobe_cnt;
        pulse_mark();
        check_mark_strobe("mid_mark");
        @(negedge clk);
        check("mid_mark_strobes", strobe_cnt, s + 1);
        recv_byte("after_mid", 8'hC3, -1, 1'b0);

        // Enable low mid-byte.
        send_mark();
        repeat (5) send_cell(1'b1);
        s = strobe_cnt;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("dis_aligned", aligned, 1'b0);
        check("dis_crc", crc, 16'hFFFF);
        enable = 1'b1;
        repeat (11) send_cell(1'b0);
        repeat (3) @(negedge clk);
        check("dis_strobes", strobe_cnt, s);
        check("dis_still_hunt", aligned, 1'b0);
        send_mark();
        send_mark();
        send_mark();
        check("reen_crc", crc, 16'hCDB4);
        recv_byte("reen_byte", 8'hFE, -1, 1'b0);

        // Reset mid-byte.
        repeat (7) send_cell(1'b1);
        s = strobe_cnt;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst2_crc", crc, 16'hFFFF);
        check("rst2_aligned", aligned, 1'b0);
        reset = 1'b0;
        repeat (9) send_cell(1'b0);
        repeat (3) @(negedge clk);
        check("rst2_strobes", strobe_cnt, s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
